cordic_rr_scheduler: RTL and testbench

- Shares one pipelined rotational CORDIC (16 stages, 1 result/cycle, start-to-done latency 15 cycles) between NREQ requesters.
- Round-robin arbitration issues one operation per cycle.
- A request ID tag travels alongside each operation in a shift register.
- Results are buffered in an output FIFO. Credit counting guarantees the FIFO never overflows, because the CORDIC pipeline cannot be stalled.

---
 rtl/cordic_rr_scheduler.sv | 136 +++++++++++++
 tb/tb_cordic_rr_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cordic_rr_scheduler.sv
// cordic_rr_scheduler: round-robin sharing of one pipelined CORDIC with tag pipe, credit control and FWFT result FIFO.
// Define CORDIC_RR_SCHEDULER_CHECK_EN to add the sticky err output.
module cordic_rr_scheduler #(
    parameter int NREQ       = 4,
    parameter int LATENCY    = 15,
    parameter int FIFO_DEPTH = 16,
    parameter int IDW        = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [16*NREQ-1:0] req_x,
    input  logic [16*NREQ-1:0] req_y,
    input  logic [16*NREQ-1:0] req_theta,
    output logic               cor_start,
    output logic [15:0]        cor_x,
    output logic [15:0]        cor_y,
    output logic [15:0]        cor_theta,
    input  logic               cor_done,
    input  logic [15:0]        cor_xprime,
    input  logic [15:0]        cor_yprime,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [IDW-1:0]     res_id,
    output logic [15:0]        res_x,
    output logic [15:0]        res_y
`ifdef CORDIC_RR_SCHEDULER_CHECK_EN
    ,
    output logic               err
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [CW-1:0]  outstanding;
    logic [IDW-1:0] ptr, win, idx, issue_id;
    logic           found, can_issue, xfer, pop, push, full, empty;
    logic [15:0]    sel_x, sel_y, sel_t;
    logic [AW:0]    wr_ptr, rd_ptr;
    logic [IDW-1:0] mem_id [FIFO_DEPTH];
    logic [15:0]    mem_x  [FIFO_DEPTH];
    logic [15:0]    mem_y  [FIFO_DEPTH];
    logic [IDW-1:0] tag_id [LATENCY];

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IDW'((int'(ptr) + i) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_t = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (IDW'(k) == win) begin
                sel_x = req_x[16*k +: 16];
                sel_y = req_y[16*k +: 16];
                sel_t = req_theta[16*k +: 16];
            end
        end
    end

    // Grants are masked during reset so nothing is offered while the block is held.
    assign can_issue = outstanding < CW'(FIFO_DEPTH);
    assign req_ready = (reset_n && can_issue && found) ? NREQ'(1) << win : '0;
    assign xfer      = |(req_valid & req_ready);
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH);
    assign res_valid = !empty;
    assign pop       = res_valid && res_ready;
    assign push      = cor_done && (!full || pop);
    assign res_id    = empty ? '0 : mem_id[rd_ptr[AW-1:0]];
    assign res_x     = empty ? '0 : mem_x[rd_ptr[AW-1:0]];
    assign res_y     = empty ? '0 : mem_y[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cor_start   <= 1'b0;
            cor_x       <= '0;
            cor_y       <= '0;
            cor_theta   <= '0;
            issue_id    <= '0;
            ptr         <= IDW'(NREQ - 1);
            outstanding <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < LATENCY; i++) tag_id[i] <= '0;
        end else begin
            cor_start <= xfer;
            if (xfer) begin
                cor_x     <= sel_x;
                cor_y     <= sel_y;
                cor_theta <= sel_t;
                issue_id  <= win;
                ptr       <= win;
            end
            tag_id[0] <= issue_id;
            for (int i = 1; i < LATENCY; i++) tag_id[i] <= tag_id[i-1];
            outstanding <= outstanding + CW'(xfer) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr[AW-1:0]] <= tag_id[LATENCY-1];
            mem_x[wr_ptr[AW-1:0]]  <= cor_xprime;
            mem_y[wr_ptr[AW-1:0]]  <= cor_yprime;
        end
    end

`ifdef CORDIC_RR_SCHEDULER_CHECK_EN
    logic tag_v [LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
            for (int i = 0; i < LATENCY; i++) tag_v[i] <= 1'b0;
        end else begin
            tag_v[0] <= cor_start;
            for (int i = 1; i < LATENCY; i++) tag_v[i] <= tag_v[i-1];
            if ((cor_done != tag_v[LATENCY-1]) || (cor_done && full && !pop)) err <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// tb_cordic_rr_scheduler: randomized scoreboard bench with a behavioural CORDIC stand-in and arbitration/credit model.
module tb_cordic_rr_scheduler;
    localparam int NREQ = 4, LAT = 15, FD = 16, IDW = 2;

    logic              clk = 1'b0, reset_n = 1'b0;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [16*NREQ-1:0] req_x, req_y, req_theta;
    logic              cor_start, cor_done;
    logic [15:0]       cor_x, cor_y, cor_theta, cor_xprime, cor_yprime;
    logic              res_valid, res_ready;
    logic [IDW-1:0]    res_id;
    logic [15:0]       res_x, res_y;
    logic              inj = 1'b0, spur = 1'b0, fixed = 1'b0;
`ifdef CORDIC_RR_SCHEDULER_CHECK_EN
    logic              err;
`endif
    int nchk = 0, nfail = 0, cyc = 0;

    always #5 clk = ~clk;

    cordic_rr_scheduler #(.NREQ(NREQ), .LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_theta(req_theta),
        .cor_start(cor_start), .cor_x(cor_x), .cor_y(cor_y), .cor_theta(cor_theta),
        .cor_done(cor_done), .cor_xprime(cor_xprime), .cor_yprime(cor_yprime),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_x(res_x), .res_y(res_y)
`ifdef CORDIC_RR_SCHEDULER_CHECK_EN
        , .err(err)
`endif
    );

    // Stand-in rotator: any fixed function of the operands, delayed LAT cycles.
    function automatic logic [31:0] cfn(input logic [15:0] x, input logic [15:0] y, input logic [15:0] t);
        return {x ^ t, y + {t[7:0], t[15:8]}};
    endfunction

    logic        pv [LAT];
    logic [31:0] pr [LAT];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= cor_start;
            pr[0] <= cfn(cor_x, cor_y, cor_theta);
            for (int i = 1; i < LAT; i++) begin
                pv[i] <= pv[i-1];
                pr[i] <= pr[i-1];
            end
        end
    end
    assign cor_done   = pv[LAT-1] | inj;
    assign cor_xprime = pr[LAT-1][31:16];
    assign cor_yprime = pr[LAT-1][15:0];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        nchk++;
        if (act !== exp_v) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp_v);
        end
    endtask

    typedef struct { logic [IDW-1:0] id; logic [31:0] r; int cyc; } exp_t;
    exp_t q[$];
    int   mptr = NREQ - 1, mout = 0;

    // Monitor: predicts the grant from round-robin/credit rules, scoreboards results in issue order.
    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        int   w;
        exp_t e;
        cyc++;
        if (!reset_n) begin
            q.delete();
            mptr = NREQ - 1;
            mout = 0;
        end else begin
            er = '0;
            w  = -1;
            if (mout < FD)
                for (int i = 1; i <= NREQ; i++)
                    if (w < 0 && req_valid[(mptr + i) % NREQ]) w = (mptr + i) % NREQ;
            if (w >= 0) er[w] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(er));
            if (!spur) chk("res_valid", 32'(res_valid), 32'(q.size() > 0 && q[0].cyc + LAT + 2 <= cyc));
            if (res_valid && res_ready && !spur && q.size() > 0) begin
                e = q.pop_front();
                chk("res_id", 32'(res_id), 32'(e.id));
                chk("res_xy", {res_x, res_y}, e.r);
            end
            if (res_valid && res_ready) mout--;
            if (w >= 0) begin
                e.id  = IDW'(w);
                e.r   = cfn(req_x[16*w +: 16], req_y[16*w +: 16], req_theta[16*w +: 16]);
                e.cyc = cyc;
                q.push_back(e);
                mptr = w;
                mout++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (!fixed) for (int k = 0; k < NREQ; k++) begin
                req_x[16*k +: 16]     = 16'($urandom);
                req_y[16*k +: 16]     = 16'($urandom);
                req_theta[16*k +: 16] = 16'($urandom);
            end
        end
    endtask

    task automatic reset_checks(input string nm);
        chk({nm, "_ready"}, 32'(req_ready), 0);
        chk({nm, "_start"}, 32'(cor_start), 0);
        chk({nm, "_cor"}, {cor_x, cor_y}, 0);
        chk({nm, "_theta"}, 32'(cor_theta), 0);
        chk({nm, "_valid"}, 32'(res_valid), 0);
        chk({nm, "_res"}, {res_x, res_y}, 0);
        chk({nm, "_id"}, 32'(res_id), 0);
    endtask

    initial begin
        logic got;
        int   stray;
        req_valid = '0; res_ready = 1'b0;
        req_x = '0; req_y = '0; req_theta = '0;
        req_valid = '1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        req_valid = '0;
        reset_n = 1'b1;
        step(2);
        fixed = 1'b1;
        req_x[47:32] = 16'h4000; req_y[47:32] = 16'h0; req_theta[47:32] = 16'h0;
        req_valid = 4'b0100;
        res_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            got = req_ready[2];
        end
        chk("single_grant", 32'(got), 1);
        step(1);
        req_valid = '0;
        fixed = 1'b0;
        step(25);
        req_valid = '1;
        step(40);
        req_valid = '0;
        step(25);
        res_ready = 1'b0;
        req_valid = '1;
        step(40);
        chk("bp_stall", 32'(req_ready), 0);
        res_ready = 1'b1;
        step(40);
        req_valid = '0;
        step(25);
        for (int i = 0; i < 400; i++) begin
            req_valid = NREQ'($urandom);
            res_ready = $urandom_range(0, 3) != 0;
            step(1);
        end
        req_valid = '0;
        res_ready = 1'b1;
        step(40);
        req_valid = '1;
        step(8);
        reset_n = 1'b0;
        #1;
        reset_checks("midrst");
        step(3);
        req_valid = '0;
        reset_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (res_valid) stray++;
        end
        chk("midrst_stray", 32'(stray), 0);
`ifdef CORDIC_RR_SCHEDULER_CHECK_EN
        step(20);
        chk("err_idle", 32'(err), 0);
        spur = 1'b1;
        res_ready = 1'b0;
        inj = 1'b1;
        @(posedge clk);
        #1;
        inj = 1'b0;
        chk("err_set", 32'(err), 1);
        step(5);
        chk("err_sticky", 32'(err), 1);
        reset_n = 1'b0;
        #1;
        chk("err_reset", 32'(err), 0);
        step(2);
        spur = 1'b0;
        reset_n = 1'b1;
        step(2);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
